// File: rtl/link_tx_sync.sv
// Clocked producer for one dual-rail delay-insensitive link (two-phase or four-phase).
// Accepts a word per valid/ready handshake and holds off the next word until the ack completes.
module link_tx_sync #(
    parameter int WIDTH       = 2,
    parameter     ENC         = "TP",
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*WIDTH-1:0]   link_data,
    input  logic                 link_ack,
    output logic                 busy,
    output logic [15:0]          tok_cnt,
    output logic                 proto_err
);

    localparam bit IS_FP = (ENC == "FP");

    generate
        if (!((ENC == "TP") || (ENC == "FP"))) begin : g_bad_enc
            $error("link_tx_sync: ENC must be \"TP\" or \"FP\"");
        end
        if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync
            $error("link_tx_sync: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        RTZ      = 2'd2,
        WAIT_RTZ = 2'd3
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   ack_ref;
    logic                   accept;

    // One asserted rail per bit: rail 2i carries a 0, rail 2i+1 carries a 1.
    function automatic logic [2*WIDTH-1:0] rail_mask(input logic [WIDTH-1:0] d);
        logic [2*WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i]) m[2*i+1] = 1'b1;
            else      m[2*i]   = 1'b1;
        end
        return m;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) ack_sync <= '0;
        else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], link_ack};
    end

    assign ack_s    = ack_sync[SYNC_STAGES-1];
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            link_data <= '0;
            tok_cnt   <= '0;
            proto_err <= 1'b0;
            ack_ref   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // An ack moving while nothing is in flight is a receiver fault; resync to it.
                    if (ack_s != ack_ref) begin
                        proto_err <= 1'b1;
                        ack_ref   <= ack_s;
                    end
                    if (accept) begin
                        link_data <= IS_FP ? rail_mask(in_data)
                                           : (link_data ^ rail_mask(in_data));
                        state     <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (IS_FP) begin
                        if (ack_s) begin
                            ack_ref <= 1'b1;
                            state   <= RTZ;
                        end
                    end else if (ack_s != ack_ref) begin
                        ack_ref <= ack_s;
                        tok_cnt <= tok_cnt + 16'd1;
                        state   <= IDLE;
                    end
                end
                RTZ: begin
                    link_data <= '0;
                    state     <= WAIT_RTZ;
                end
                WAIT_RTZ: begin
                    if (!ack_s) begin
                        ack_ref <= 1'b0;
                        tok_cnt <= tok_cnt + 16'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_link_tx_sync.sv
// Bench for link_tx_sync: one two-phase and one four-phase instance driven with random words,
// compared against a token-level model of the dual-rail encoding and ack handshake.
module tb_link_tx_sync;

    localparam int W  = 2;
    localparam int SS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [W-1:0]    tp_in_data, fp_in_data;
    logic            tp_in_valid, fp_in_valid;
    logic            tp_in_ready, fp_in_ready;
    logic [2*W-1:0]  tp_link, fp_link;
    logic            tp_ack, fp_ack;
    logic            tp_busy, fp_busy;
    logic [15:0]     tp_cnt, fp_cnt;
    logic            tp_err, fp_err;

    link_tx_sync #(.WIDTH(W), .ENC("TP"), .SYNC_STAGES(SS)) dut_tp (
        .clk(clk), .rst(rst), .in_data(tp_in_data), .in_valid(tp_in_valid),
        .in_ready(tp_in_ready), .link_data(tp_link), .link_ack(tp_ack),
        .busy(tp_busy), .tok_cnt(tp_cnt), .proto_err(tp_err)
    );

    link_tx_sync #(.WIDTH(W), .ENC("FP"), .SYNC_STAGES(SS)) dut_fp (
        .clk(clk), .rst(rst), .in_data(fp_in_data), .in_valid(fp_in_valid),
        .in_ready(fp_in_ready), .link_data(fp_link), .link_ack(fp_ack),
        .busy(fp_busy), .tok_cnt(fp_cnt), .proto_err(fp_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tp_acc_cyc;

    logic [2*W-1:0] tp_exp_link, fp_exp_link;
    int             tp_exp_cnt, fp_exp_cnt;
    logic           tp_exp_err;

    int             fp_changes = 0;
    logic [2*W-1:0] fp_prev    = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        fp_changes <= fp_changes + ((fp_link !== fp_prev) ? 1 : 0);
        fp_prev    <= fp_link;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Rail set for a word, computed as a sum of powers of two: bit i selects rail 2i + value.
    function automatic logic [2*W-1:0] word_rails(input logic [W-1:0] w);
        int acc;
        acc = 0;
        for (int i = 0; i < W; i++) acc += (1 << (2*i + int'(w[i])));
        return (2*W)'(acc);
    endfunction

    task automatic tp_send(input logic [W-1:0] w, input int gap);
        int n;
        int lat;
        n = 0;
        while (!tp_in_ready && n < 20) begin @(negedge clk); n++; end
        check("tp_ready_before_send", 32'(tp_in_ready), 32'd1);
        tp_in_data  = w;
        tp_in_valid = 1'b1;
        @(negedge clk);
        tp_acc_cyc  = cyc;
        tp_in_valid = 1'b0;
        tp_in_data  = W'($urandom);
        tp_exp_link = tp_exp_link ^ word_rails(w);
        check("tp_link_after_accept", 32'(tp_link), 32'(tp_exp_link));
        check("tp_busy_in_flight", 32'(tp_busy), 32'd1);
        check("tp_ready_in_flight", 32'(tp_in_ready), 32'd0);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check("tp_link_static_no_ack", 32'(tp_link), 32'(tp_exp_link));
            check("tp_ready_held_no_ack", 32'(tp_in_ready), 32'd0);
        end
        tp_ack = ~tp_ack;
        lat = 0;
        while (!tp_in_ready && lat < 10) begin @(negedge clk); lat++; end
        check("tp_ack_latency_in_range", 32'((lat >= SS+1) && (lat <= SS+2)), 32'd1);
        tp_exp_cnt++;
        check("tp_tok_cnt", 32'(tp_cnt), 32'(tp_exp_cnt & 16'hFFFF));
        check("tp_link_after_ack", 32'(tp_link), 32'(tp_exp_link));
        check("tp_busy_after_ack", 32'(tp_busy), 32'd0);
        check("tp_proto_err", 32'(tp_err), 32'(tp_exp_err));
    endtask

    task automatic fp_send(input logic [W-1:0] w, input int gap);
        int n;
        int lat;
        int ch0;
        n = 0;
        while (!fp_in_ready && n < 20) begin @(negedge clk); n++; end
        check("fp_ready_before_send", 32'(fp_in_ready), 32'd1);
        ch0 = fp_changes;
        fp_in_data  = w;
        fp_in_valid = 1'b1;
        @(negedge clk);
        fp_in_valid = 1'b0;
        fp_in_data  = W'($urandom);
        fp_exp_link = word_rails(w);
        check("fp_link_after_accept", 32'(fp_link), 32'(fp_exp_link));
        check("fp_busy_in_flight", 32'(fp_busy), 32'd1);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check("fp_link_static_no_ack", 32'(fp_link), 32'(fp_exp_link));
        end
        fp_ack = 1'b1;
        lat = 0;
        while (fp_link != '0 && lat < 10) begin @(negedge clk); lat++; end
        check("fp_rtz_latency_in_range", 32'((lat >= SS+2) && (lat <= SS+3)), 32'd1);
        fp_exp_link = '0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check("fp_ready_held_until_ack_low", 32'(fp_in_ready), 32'd0);
        end
        check("fp_busy_waiting_rtz", 32'(fp_busy), 32'd1);
        fp_ack = 1'b0;
        lat = 0;
        while (!fp_in_ready && lat < 10) begin @(negedge clk); lat++; end
        check("fp_ack_low_latency_in_range", 32'((lat >= SS+1) && (lat <= SS+2)), 32'd1);
        fp_exp_cnt++;
        check("fp_tok_cnt", 32'(fp_cnt), 32'(fp_exp_cnt));
        check("fp_link_idle_zero", 32'(fp_link), 32'd0);
        check("fp_two_rail_events_per_token", 32'(fp_changes - ch0), 32'd2);
        check("fp_proto_err", 32'(fp_err), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_acc;
        rst = 1'b1;
        tp_in_data = '0; tp_in_valid = 1'b0; tp_ack = 1'b0;
        fp_in_data = '0; fp_in_valid = 1'b0; fp_ack = 1'b0;
        tp_exp_link = '0; fp_exp_link = '0;
        tp_exp_cnt = 0; fp_exp_cnt = 0; tp_exp_err = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tp_link", 32'(tp_link), 32'd0);
        check("rst_tp_ready", 32'(tp_in_ready), 32'd0);
        check("rst_tp_busy", 32'(tp_busy), 32'd0);
        check("rst_tp_cnt", 32'(tp_cnt), 32'd0);
        check("rst_tp_err", 32'(tp_err), 32'd0);
        check("rst_fp_link", 32'(fp_link), 32'd0);
        check("rst_fp_ready", 32'(fp_in_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_tp_ready", 32'(tp_in_ready), 32'd1);
        check("post_rst_fp_ready", 32'(fp_in_ready), 32'd1);

        // Directed two-phase sequence: 10, 10, 01.
        tp_send(2'b10, 3);
        check("tp_first_token_rails", 32'(tp_link), 32'h9);
        tp_send(2'b10, 2);
        check("tp_second_token_rails", 32'(tp_link), 32'h0);
        tp_send(2'b01, 4);
        check("tp_third_token_rails", 32'(tp_link), 32'h6);

        // Idle link stays put with in_valid low and noisy data.
        for (int i = 0; i < 5; i++) begin
            tp_in_data = W'($urandom);
            @(negedge clk);
            check("tp_idle_static", 32'(tp_link), 32'(tp_exp_link));
        end

        // Spurious ack while idle.
        tp_ack = ~tp_ack;
        for (int i = 0; i < SS+3; i++) begin
            @(negedge clk);
            check("tp_spurious_link_static", 32'(tp_link), 32'(tp_exp_link));
        end
        tp_exp_err = 1'b1;
        check("tp_spurious_sets_err", 32'(tp_err), 32'd1);
        check("tp_spurious_cnt_unchanged", 32'(tp_cnt), 32'(tp_exp_cnt));
        tp_send(W'($urandom), 1);

        // Ack toggle landing on the same edge as an accept: token still sent.
        tp_exp_err = 1'b0;
        tp_ack = ~tp_ack;
        repeat (2) @(negedge clk);
        tp_in_data  = 2'b11;
        tp_in_valid = 1'b1;
        @(negedge clk);
        tp_in_valid = 1'b0;
        tp_exp_link = tp_exp_link ^ word_rails(2'b11);
        tp_exp_err  = 1'b1;
        check("tp_collide_link", 32'(tp_link), 32'(tp_exp_link));
        check("tp_collide_err", 32'(tp_err), 32'd1);
        check("tp_collide_busy", 32'(tp_busy), 32'd1);
        repeat (SS+2) @(negedge clk);
        check("tp_collide_still_waiting", 32'(tp_in_ready), 32'd0);
        tp_ack = ~tp_ack;
        begin
            int n;
            n = 0;
            while (!tp_in_ready && n < 10) begin @(negedge clk); n++; end
        end
        tp_exp_cnt++;
        check("tp_collide_completes", 32'(tp_cnt), 32'(tp_exp_cnt));

        // Randomised two-phase traffic.
        for (int k = 0; k < 24; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            tp_send(W'($urandom), int'($urandom_range(0, 4)));
        end

        // Back-to-back throughput with an immediately responding receiver.
        prev_acc = 0;
        for (int k = 0; k < 150; k++) begin
            tp_send(W'($urandom), 0);
            if (k > 0)
                check("tp_throughput_in_range",
                      32'((tp_acc_cyc - prev_acc >= SS+2) && (tp_acc_cyc - prev_acc <= SS+3)), 32'd1);
            prev_acc = tp_acc_cyc;
        end

        // Reset in the middle of a token.
        tp_in_data  = 2'b01;
        tp_in_valid = 1'b1;
        @(negedge clk);
        tp_in_valid = 1'b0;
        check("tp_pre_reset_link", 32'(tp_link), 32'(tp_exp_link ^ word_rails(2'b01)));
        rst = 1'b1;
        tp_ack = 1'b0;
        fp_ack = 1'b0;
        @(negedge clk);
        check("midrst_link", 32'(tp_link), 32'd0);
        check("midrst_cnt", 32'(tp_cnt), 32'd0);
        check("midrst_ready", 32'(tp_in_ready), 32'd0);
        check("midrst_busy", 32'(tp_busy), 32'd0);
        check("midrst_err", 32'(tp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tp_exp_link = '0; tp_exp_cnt = 0; tp_exp_err = 1'b0;
        fp_exp_link = '0; fp_exp_cnt = 0;
        #1;
        check("midrst_ready_on_release", 32'(tp_in_ready), 32'd1);
        @(negedge clk);
        check("midrst_ready_cycle_after", 32'(tp_in_ready), 32'd1);
        check("midrst_no_completion", 32'(tp_cnt), 32'd0);
        tp_send(2'b10, 1);
        check("midrst_fresh_rails", 32'(tp_link), 32'h9);

        // Four-phase: directed 11, then random traffic.
        fp_send(2'b11, 2);
        check("fp_cnt_after_first", 32'(fp_cnt), 32'd1);
        for (int k = 0; k < 20; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            fp_send(W'($urandom), int'($urandom_range(0, 3)));
        end
        check("fp_tp_untouched_cnt", 32'(tp_cnt), 32'(tp_exp_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
